pid_mac_seq: RTL and testbench
==============================

Name: pid_mac_seq

Overview:
- Multi-channel fixed-point PID/IIR controller for the fan-control loop.
- Computes y[n] = b2·e[n] + b1·e[n-1] + b0·e[n-2] − a1·y[n-1] − a0·y[n-2] for NUM_CH channels.
- A single shared multiplier-accumulator is time-multiplexed across all terms and channels, replacing a fully parallel single-channel datapath.
- Sits between the ADC sample registers and the PWM generators. Triggered by the PID rate strobe; reports busy/done/overrun.

Parameters:
ADC_BITWIDTH, 8, width of unsigned ADC and setpoint values
REG_BITWIDTH, 8, width of signed two's-complement coefficients
COEF_FRAC, 4, fractional bits of coefficients (16 = 1.0 at defaults)
OUT_FRAC, 4, fractional bits kept in internal output state
NUM_CH, 2, number of independent control channels (1..8)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
clk_en_PID_i  in  1  one-cycle strobe; starts a sweep over all channels
ADC_value_i  in  NUM_CH*ADC_BITWIDTH  packed ADC readings; channel k at bits [k*ADC_BITWIDTH +: ADC_BITWIDTH]
SET_value_i  in  NUM_CH*ADC_BITWIDTH  packed setpoints; same packing
a1_reg_i, a0_reg_i, b0_reg_i, b1_reg_i, b2_reg_i  in  REG_BITWIDTH each  signed coefficients, shared by all channels
out_Val_o  out  NUM_CH*(ADC_BITWIDTH+1)  packed signed outputs, integer part of y
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse when a sweep completes
overrun_o  out  1  sticky flag; strobe received while busy

Behaviour:
- Reset is asynchronous on rst_i high. While in reset:
  - all outputs are 0, state is IDLE;
  - every channel's e1, e2, y1 and y2 history is 0.
- Widths:
  - E_W = ADC_BITWIDTH+1; e = SET − ADC, signed.
  - Y_W = ADC_BITWIDTH+1+OUT_FRAC.
  - ACC_W = REG_BITWIDTH+Y_W+3.
- Strobe in IDLE: in that cycle, capture the ADC inputs, setpoint inputs and all five coefficients into snapshot registers. busy_o goes high in the next cycle. Later input changes do not affect the sweep.
- FSM states and transitions:
  - IDLE → MAC (ch=0, tap=0).
  - MAC: one product per cycle, taps in order b2·(e<<<OUT_FRAC), b1·(e1<<<OUT_FRAC), b0·(e2<<<OUT_FRAC), −a1·y1, −a0·y2. Accumulator is cleared at tap 0. After tap 4 → WB.
  - WB: y_new = sat(acc >>> COEF_FRAC), arithmetic shift (floor). Then e2←e1, e1←e, y2←y1, y1←y_new, and out_Val_o[ch] ← y_new >>> OUT_FRAC. If ch<NUM_CH−1: ch+1, → MAC. Else → DONE.
  - DONE: done_o=1 for one cycle, busy_o drops in the same cycle → IDLE.
- Latency: 6 cycles per channel. The strobe-to-done_o pulse is 6·NUM_CH+1 cycles.
- Output timing: a channel's out_Val_o updates at its own WB. Other channels hold their values.
- Saturation: clamp y_new to [−2^(Y_W−1), 2^(Y_W−1)−1]. This limits out_Val_o to [−2^ADC_BITWIDTH, 2^ADC_BITWIDTH−1]. The clamped value is what enters history.
- Strobe while busy_o=1 or in DONE: ignored, the sweep is not restarted, and overrun_o is set. overrun_o clears only on reset.
- Reset mid-sweep: the sweep is aborted, history and outputs go to 0, and no done_o pulse is produced.
- NUM_CH=1 must be supported (sweep = 7 cycles).

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- Defined: at WB, if y_new saturates at the same limit that y1 already holds, that channel's e1/e2/y1/y2 are frozen (not shifted). out_Val_o keeps the limit value. A saturating result in the opposite direction, or a non-saturating result, updates normally.
- Undefined: history always shifts with the clamped value.

Test Plan:
- Defaults; b2=16, others 0; ch0 SET=100 ADC=60; strobe → done_o exactly 13 cycles after strobe; out ch0 = 40; busy_o high for 12 cycles.
- b2=16; ch1 SET=0 ADC=255; strobe → out ch1 = −255. ch0 SET=ADC → out ch0 = 0.
- Integrator: a1=−16, b2=16; ch0 SET=61 ADC=60; five strobes (each after done) → out ch0 = 1,2,3,4,5.
- Saturation: b2=127; SET=255 ADC=0 → out = 255. SET=0 ADC=255 → out = −256.
- Overrun: second strobe 3 cycles after the first → no restart, done_o still at 13 cycles, overrun_o = 1 until rst_i.
- Anti-windup (macro on): a1=−16, b2=127, e=200, strobe ×3 (out = 255, y1 frozen at limit); then e=−1, b2=16, strobe → out = 254. With macro off, same final out = 254 (history holds the clamp). Also assert rst_i mid-sweep → outputs 0, no done_o pulse.

Source files
------------

// File: rtl/pid_mac_seq.sv
// rtl/pid_mac_seq.sv - multi-channel PID/IIR controller on one shared time-multiplexed MAC
// Optional anti-windup history freeze: define PID_ANTIWINDUP_EN.

module pid_mac_seq #(
  parameter int ADC_BITWIDTH = 8,
  parameter int REG_BITWIDTH = 8,
  parameter int COEF_FRAC    = 4,
  parameter int OUT_FRAC     = 4,
  parameter int NUM_CH       = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clk_en_PID_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0]      ADC_value_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0]      SET_value_i,
  input  logic [REG_BITWIDTH-1:0]             a1_reg_i,
  input  logic [REG_BITWIDTH-1:0]             a0_reg_i,
  input  logic [REG_BITWIDTH-1:0]             b0_reg_i,
  input  logic [REG_BITWIDTH-1:0]             b1_reg_i,
  input  logic [REG_BITWIDTH-1:0]             b2_reg_i,
  output logic [NUM_CH*(ADC_BITWIDTH+1)-1:0]  out_Val_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                overrun_o
);

  localparam int E_W   = ADC_BITWIDTH + 1;
  localparam int Y_W   = ADC_BITWIDTH + 1 + OUT_FRAC;
  localparam int ACC_W = REG_BITWIDTH + Y_W + 3;
  localparam int P_W   = REG_BITWIDTH + Y_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [Y_W-1:0]   Y_MAX   = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0]   Y_MIN   = {1'b1, {(Y_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX_A = {{(ACC_W-Y_W){1'b0}}, Y_MAX};
  localparam logic signed [ACC_W-1:0] Y_MIN_A = {{(ACC_W-Y_W){1'b1}}, Y_MIN};
  localparam logic [CH_W-1:0]         CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0] ch_q, ch_d;
  logic [2:0]      tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [NUM_CH*ADC_BITWIDTH-1:0] adc_q, adc_d, set_q, set_d;
  logic signed [REG_BITWIDTH-1:0] a1_q, a1_d, a0_q, a0_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;

  logic signed [E_W-1:0] e1_q [NUM_CH];
  logic signed [E_W-1:0] e1_d [NUM_CH];
  logic signed [E_W-1:0] e2_q [NUM_CH];
  logic signed [E_W-1:0] e2_d [NUM_CH];
  logic signed [Y_W-1:0] y1_q [NUM_CH];
  logic signed [Y_W-1:0] y1_d [NUM_CH];
  logic signed [Y_W-1:0] y2_q [NUM_CH];
  logic signed [Y_W-1:0] y2_d [NUM_CH];

  logic [NUM_CH*E_W-1:0] out_q, out_d;
  logic                  overrun_q, overrun_d;

  logic [ADC_BITWIDTH-1:0] set_sel, adc_sel;
  logic signed [E_W-1:0]   e_cur;

  logic signed [REG_BITWIDTH-1:0] coef_m;
  logic signed [Y_W-1:0]          opnd_m;
  logic                           sub_m;
  logic signed [P_W-1:0]          prod;
  logic signed [ACC_W-1:0]        prod_ext, acc_base, acc_mac;

  logic signed [ACC_W-1:0] acc_shr;
  logic                    sat_hi, sat_lo, freeze;
  logic signed [Y_W-1:0]   y_new;
  logic signed [E_W-1:0]   y_out;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clk_en_PID_i) state_d = S_MAC;
      S_MAC:   if (tap_q == 3'd4) state_d = S_WB;
      S_WB:    state_d = (ch_q == CH_LAST) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_MAC, S_WB: busy_o = 1'b1;
      S_DONE:      done_o = 1'b1;
      default: ;
    endcase
  end

  // Error of the channel being processed, from the snapshot taken at the strobe
  always_comb begin
    set_sel = set_q[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH];
    adc_sel = adc_q[ch_q*ADC_BITWIDTH +: ADC_BITWIDTH];
    e_cur   = $signed({1'b0, set_sel}) - $signed({1'b0, adc_sel});
  end

  // Feedback taps subtract the product so a coefficient of -2^(W-1) never needs negating
  always_comb begin
    coef_m = b2_q;
    opnd_m = {e_cur, {OUT_FRAC{1'b0}}};
    sub_m  = 1'b0;
    case (tap_q)
      3'd1: begin
        coef_m = b1_q;
        opnd_m = {e1_q[ch_q], {OUT_FRAC{1'b0}}};
      end
      3'd2: begin
        coef_m = b0_q;
        opnd_m = {e2_q[ch_q], {OUT_FRAC{1'b0}}};
      end
      3'd3: begin
        coef_m = a1_q;
        opnd_m = y1_q[ch_q];
        sub_m  = 1'b1;
      end
      3'd4: begin
        coef_m = a0_q;
        opnd_m = y2_q[ch_q];
        sub_m  = 1'b1;
      end
      default: ;
    endcase
    prod     = P_W'(coef_m) * P_W'(opnd_m);
    prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    acc_base = (tap_q == 3'd0) ? '0 : acc_q;
    acc_mac  = sub_m ? (acc_base - prod_ext) : (acc_base + prod_ext);
  end

  always_comb begin
    acc_shr = acc_q >>> COEF_FRAC;
    sat_hi  = (acc_shr > Y_MAX_A);
    sat_lo  = (acc_shr < Y_MIN_A);
    if (sat_hi) begin
      y_new = Y_MAX;
    end else if (sat_lo) begin
      y_new = Y_MIN;
    end else begin
      y_new = acc_shr[Y_W-1:0];
    end
    y_out = y_new[Y_W-1:OUT_FRAC];
`ifdef PID_ANTIWINDUP_EN
    freeze = (sat_hi && (y1_q[ch_q] == Y_MAX)) || (sat_lo && (y1_q[ch_q] == Y_MIN));
`else
    freeze = 1'b0;
`endif
  end

  always_comb begin
    ch_d      = ch_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    adc_d     = adc_q;
    set_d     = set_q;
    a1_d      = a1_q;
    a0_d      = a0_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    out_d     = out_q;
    overrun_d = overrun_q | (clk_en_PID_i && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (clk_en_PID_i) begin
          adc_d = ADC_value_i;
          set_d = SET_value_i;
          a1_d  = a1_reg_i;
          a0_d  = a0_reg_i;
          b0_d  = b0_reg_i;
          b1_d  = b1_reg_i;
          b2_d  = b2_reg_i;
          ch_d  = '0;
          tap_d = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_mac;
        tap_d = (tap_q == 3'd4) ? 3'd0 : tap_q + 3'd1;
      end
      S_WB: begin
        out_d[ch_q*E_W +: E_W] = y_out;
        if (!freeze) begin
          e2_d[ch_q] = e1_q[ch_q];
          e1_d[ch_q] = e_cur;
          y2_d[ch_q] = y1_q[ch_q];
          y1_d[ch_q] = y_new;
        end
        tap_d = 3'd0;
        if (ch_q != CH_LAST) ch_d = ch_q + CH_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q      <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      adc_q     <= '0;
      set_q     <= '0;
      a1_q      <= '0;
      a0_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        e1_q[i] <= '0;
        e2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      ch_q      <= ch_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      adc_q     <= adc_d;
      set_q     <= set_d;
      a1_q      <= a1_d;
      a0_q      <= a0_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
    end
  end

  assign out_Val_o = out_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pid_mac_seq.sv
// tb/tb_pid_mac_seq.sv - self-checking bench for pid_mac_seq (vector table, corner sequences, random vs model)

module tb_pid_mac_seq;

  localparam int ADC_W = 8;
  localparam int REG_W = 8;
  localparam int NCH   = 2;
  localparam int EW    = ADC_W + 1;
  localparam int CSCL  = 16;
  localparam int OSCL  = 16;
  localparam int YMAX  = 4095;
  localparam int YMIN  = -4096;

  logic clk = 1'b0;
  logic rst;
  logic strobe;
  logic [NCH*ADC_W-1:0] adc, setv;
  logic [REG_W-1:0] a1, a0, b0, b1, b2;
  logic [NCH*EW-1:0] outv;
  logic busy, done, ovr;

  always #5 clk = ~clk;

  pid_mac_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clk_en_PID_i (strobe),
    .ADC_value_i  (adc),
    .SET_value_i  (setv),
    .a1_reg_i     (a1),
    .a0_reg_i     (a0),
    .b0_reg_i     (b0),
    .b1_reg_i     (b1),
    .b2_reg_i     (b2),
    .out_Val_o    (outv),
    .busy_o       (busy),
    .done_o       (done),
    .overrun_o    (ovr)
  );

  int vectors = 0;
  int miscompares = 0;

  int cur_set [NCH];
  int cur_adc [NCH];
  int cur_a1, cur_a0, cur_b0, cur_b1, cur_b2;

  int me1 [NCH];
  int me2 [NCH];
  int my1 [NCH];
  int my2 [NCH];
  int mout [NCH];

  typedef struct {
    bit rst_first;
    int s0, d0, s1, d1;
    int ca1, cb2;
    int x0, x1;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_ch(input int k);
    logic signed [EW-1:0] v;
    v = outv[k*EW +: EW];
    return int'(v);
  endfunction

  function automatic int fdiv(input longint v, input int d);
    longint q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      me1[k] = 0; me2[k] = 0; my1[k] = 0; my2[k] = 0; mout[k] = 0;
    end
  endtask

  // y = floor(sum/2^COEF_FRAC), clamped; history shifts unless anti-windup holds it
  task automatic model_sweep();
    for (int k = 0; k < NCH; k++) begin
      longint acc;
      int e, raw, y;
      bit hold;
      e   = cur_set[k] - cur_adc[k];
      acc = longint'(cur_b2) * e * OSCL + longint'(cur_b1) * me1[k] * OSCL
          + longint'(cur_b0) * me2[k] * OSCL - longint'(cur_a1) * my1[k]
          - longint'(cur_a0) * my2[k];
      raw = fdiv(acc, CSCL);
      y = (raw > YMAX) ? YMAX : (raw < YMIN) ? YMIN : raw;
      hold = 1'b0;
`ifdef PID_ANTIWINDUP_EN
      hold = ((raw > YMAX) && (my1[k] == YMAX)) || ((raw < YMIN) && (my1[k] == YMIN));
`endif
      if (!hold) begin
        me2[k] = me1[k]; me1[k] = e;
        my2[k] = my1[k]; my1[k] = y;
      end
      mout[k] = fdiv(longint'(y), OSCL);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      adc[k*ADC_W +: ADC_W]  = 8'(cur_adc[k]);
      setv[k*ADC_W +: ADC_W] = 8'(cur_set[k]);
    end
    a1 = 8'(cur_a1); a0 = 8'(cur_a0); b0 = 8'(cur_b0); b1 = 8'(cur_b1); b2 = 8'(cur_b2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // lat = cycles from strobe cycle to done_o (-1 on timeout); bcnt = busy cycles seen
  task automatic run_sweep(input int ovr_at, input bit perturb, output int lat, output int bcnt);
    @(negedge clk);
    drive();
    strobe = 1'b1;
    lat = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      strobe = (k == ovr_at);
      if (perturb && k == 2) begin
        adc = 16'($urandom); setv = 16'($urandom);
        a1 = 8'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
        b1 = 8'($urandom); b2 = 8'($urandom);
      end
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    strobe = 1'b0;
  endtask

  function automatic int rcoef(input bit wide);
    return wide ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 48)) - 24;
  endfunction

  initial begin
    int lat, bcnt, dcnt;

    tbl[0]  = '{1'b1, 100,  60,   0, 255,   0,  16,  40, -255};
    tbl[1]  = '{1'b1,  77,  77,   0, 255,   0,  16,   0, -255};
    tbl[2]  = '{1'b1,  61,  60,  60,  61, -16,  16,   1,   -1};
    tbl[3]  = '{1'b0,  61,  60,  60,  61, -16,  16,   2,   -2};
    tbl[4]  = '{1'b0,  61,  60,  60,  61, -16,  16,   3,   -3};
    tbl[5]  = '{1'b0,  61,  60,  60,  61, -16,  16,   4,   -4};
    tbl[6]  = '{1'b0,  61,  60,  60,  61, -16,  16,   5,   -5};
    tbl[7]  = '{1'b1, 255,   0,   0, 255,   0, 127, 255, -256};
    tbl[8]  = '{1'b1, 200,   0,   0, 200, -16, 127, 255, -256};
    tbl[9]  = '{1'b0, 200,   0,   0, 200, -16, 127, 255, -256};
    tbl[10] = '{1'b0, 200,   0,   0, 200, -16, 127, 255, -256};
    tbl[11] = '{1'b0,   0,   1,   1,   0, -16,  16, 254, -255};

    rst = 1'b1; strobe = 1'b0; adc = '0; setv = '0;
    a1 = '0; a0 = '0; b0 = '0; b1 = '0; b2 = '0;
    cur_a0 = 0; cur_b0 = 0; cur_b1 = 0;
    repeat (2) @(negedge clk);
    check("reset_out0", out_ch(0), 0);
    check("reset_out1", out_ch(1), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_overrun", int'(ovr), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_first) do_reset();
      cur_set[0] = tbl[i].s0; cur_adc[0] = tbl[i].d0;
      cur_set[1] = tbl[i].s1; cur_adc[1] = tbl[i].d1;
      cur_a1 = tbl[i].ca1; cur_b2 = tbl[i].cb2;
      cur_a0 = 0; cur_b0 = 0; cur_b1 = 0;
      run_sweep(0, 1'b0, lat, bcnt);
      check($sformatf("tbl%0d_latency", i), lat, 13);
      check($sformatf("tbl%0d_busy_cycles", i), bcnt, 12);
      check($sformatf("tbl%0d_out0", i), out_ch(0), tbl[i].x0);
      check($sformatf("tbl%0d_out1", i), out_ch(1), tbl[i].x1);
      check($sformatf("tbl%0d_overrun", i), int'(ovr), 0);
    end

    // Reset mid-sweep on top of nonzero history: no done_o, everything cleared
    @(negedge clk);
    drive();
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out0", out_ch(0), 0);
    check("midrst_out1", out_ch(1), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    cur_a1 = -16; cur_b2 = 0;
    run_sweep(0, 1'b0, lat, bcnt);
    check("midrst_hist0", out_ch(0), 0);
    check("midrst_hist1", out_ch(1), 0);

    // Overrun: second strobe during the sweep neither restarts nor stretches it
    do_reset();
    cur_set[0] = 100; cur_adc[0] = 60; cur_set[1] = 0; cur_adc[1] = 255;
    cur_a1 = 0; cur_b2 = 16;
    run_sweep(3, 1'b0, lat, bcnt);
    check("ovr_latency", lat, 13);
    check("ovr_out0", out_ch(0), 40);
    check("ovr_flag", int'(ovr), 1);
    repeat (5) @(negedge clk);
    check("ovr_idle_done", int'(done), 0);
    run_sweep(0, 1'b0, lat, bcnt);
    check("ovr_sticky", int'(ovr), 1);
    check("ovr_next_latency", lat, 13);
    do_reset();
    check("ovr_cleared", int'(ovr), 0);

    // Randomised sweeps with inputs scrambled mid-sweep, against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NCH; k++) begin
        cur_set[k] = int'($urandom_range(0, 255));
        cur_adc[k] = (i % 3 == 0) ? int'($urandom_range(0, 255))
                                  : cur_set[k] - int'($urandom_range(0, 20)) + 10;
        if (cur_adc[k] < 0) cur_adc[k] = 0;
        if (cur_adc[k] > 255) cur_adc[k] = 255;
      end
      cur_a1 = rcoef(i % 4 == 0); cur_a0 = rcoef(i % 4 == 0);
      cur_b0 = rcoef(i % 4 == 1); cur_b1 = rcoef(i % 4 == 1); cur_b2 = rcoef(i % 4 == 2);
      run_sweep(0, 1'b1, lat, bcnt);
      model_sweep();
      check($sformatf("rnd%0d_latency", i), lat, 13);
      for (int k = 0; k < NCH; k++)
        check($sformatf("rnd%0d_out%0d", i, k), out_ch(k), mout[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
